// File: rtl/delay_line_ctrl_if.sv
//==============================================================================
// delay_line_ctrl_if: single-port synchronous RAM bus used by the delay-line controller
// Revision: 1.0
//==============================================================================
`default_nettype none

interface delay_line_ctrl_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 11
);
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport master (
    output ram_addr,
    output ram_we,
    output ram_wdata,
    input  ram_rdata
  );

  modport slave (
    input  ram_addr,
    input  ram_we,
    input  ram_wdata,
    output ram_rdata
  );
endinterface

`default_nettype wire

// File: rtl/delay_line_ctrl.sv
//==============================================================================
// delay_line_ctrl: frame-timed multi-tap circular delay line with fill guard and delay-0 bypass
// Revision: 1.0
//==============================================================================
`default_nettype none

module delay_line_ctrl #(
  parameter int ADDR_W       = 13,
  parameter int DATA_W       = 11,
  parameter int NTAPS        = 4,
  parameter int FRAME_CYCLES = 833,
  parameter int RAM_LAT      = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_W-1:0]       sample_in,
  input  logic [NTAPS*ADDR_W-1:0] tap_delay,
  input  logic [NTAPS-1:0]        tap_en,
  delay_line_ctrl_if.master       ram,
  output logic                    frame_start,
  output logic [NTAPS*DATA_W-1:0] tap_data,
  output logic                    taps_valid,
  output logic [ADDR_W-1:0]       wr_ptr
);

  localparam int c_fc_w    = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam int c_idx_w   = (NTAPS > 1) ? $clog2(NTAPS) : 1;
  localparam int c_cnt_max = (NTAPS > RAM_LAT) ? NTAPS : RAM_LAT;
  localparam int c_cnt_w   = $clog2(c_cnt_max + 1);

  localparam logic [c_fc_w-1:0]  c_fc_last  = c_fc_w'(FRAME_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_last_tap = c_cnt_w'(NTAPS - 1);
  localparam logic [c_cnt_w-1:0] c_last_lat = c_cnt_w'(RAM_LAT - 1);

  localparam logic [2:0] c_idle  = 3'd0;
  localparam logic [2:0] c_read  = 3'd1;
  localparam logic [2:0] c_drain = 3'd2;
  localparam logic [2:0] c_write = 3'd3;
  localparam logic [2:0] c_done  = 3'd4;

  logic [c_fc_w-1:0]        fc_q, fc_d;
  logic [2:0]               state_q, state_d;
  logic [c_cnt_w-1:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0]        sample_q, sample_d;
  logic [NTAPS*ADDR_W-1:0]  delay_q, delay_d;
  logic [NTAPS-1:0]         en_q, en_d;
  logic [ADDR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]        fill_q, fill_d;
  logic [NTAPS*DATA_W-1:0]  tap_data_q, tap_data_d;
  logic                     taps_valid_q, taps_valid_d;
  logic [DATA_W-1:0]        shadow_q [NTAPS];
  logic [DATA_W-1:0]        shadow_d [NTAPS];
  logic                     pipe_vld_q [RAM_LAT];
  logic                     pipe_vld_d [RAM_LAT];
  logic [c_idx_w-1:0]       pipe_idx_q [RAM_LAT];
  logic [c_idx_w-1:0]       pipe_idx_d [RAM_LAT];

  logic [ADDR_W-1:0]        rd_delay;
  logic [ADDR_W-1:0]        tap_d;
  logic                     cap_vld;
  logic [c_idx_w-1:0]       cap_idx;

  assign frame_start = (fc_q == '0);
  assign tap_data    = tap_data_q;
  assign taps_valid  = taps_valid_q;
  assign wr_ptr      = wr_ptr_q;

  // RAM port: read addresses use natural modulo wrap of the write pointer
  always_comb begin
    rd_delay      = delay_q[cnt_q*ADDR_W +: ADDR_W];
    ram.ram_we    = 1'b0;
    ram.ram_addr  = wr_ptr_q;
    ram.ram_wdata = sample_q;
    if (state_q == c_read) begin
      ram.ram_addr = wr_ptr_q - rd_delay;
    end
    if (state_q == c_write) begin
      ram.ram_we = 1'b1;
    end
  end

  always_comb begin
    fc_d         = (fc_q == c_fc_last) ? '0 : fc_q + 1'b1;
    state_d      = state_q;
    cnt_d        = cnt_q;
    sample_d     = sample_q;
    delay_d      = delay_q;
    en_d         = en_q;
    wr_ptr_d     = wr_ptr_q;
    fill_d       = fill_q;
    tap_data_d   = tap_data_q;
    taps_valid_d = 1'b0;

    if (frame_start) begin
      sample_d = sample_in;
      delay_d  = tap_delay;
      en_d     = tap_en;
    end

    case (state_q)
      c_idle: begin
        if (frame_start) begin
          state_d = c_read;
          cnt_d   = '0;
        end
      end
      c_read: begin
        if (cnt_q == c_last_tap) begin
          state_d = c_drain;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      c_drain: begin
        if (cnt_q == c_last_lat) begin
          state_d = c_write;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      c_write: begin
        wr_ptr_d     = wr_ptr_q + 1'b1;
        fill_d       = (fill_q == '1) ? fill_q : fill_q + 1'b1;
        taps_valid_d = 1'b1;
        state_d      = c_done;
        for (int i = 0; i < NTAPS; i++) begin
          tap_data_d[i*DATA_W +: DATA_W] = shadow_q[i];
        end
      end
      c_done: begin
        state_d = c_idle;
      end
      default: begin
        state_d = c_idle;
      end
    endcase
  end

  // Tap index travels alongside the RAM read so each return lands in its own slot
  always_comb begin
    pipe_vld_d[0] = (state_q == c_read);
    pipe_idx_d[0] = cnt_q[c_idx_w-1:0];
    for (int k = 1; k < RAM_LAT; k++) begin
      pipe_vld_d[k] = pipe_vld_q[k-1];
      pipe_idx_d[k] = pipe_idx_q[k-1];
    end
    cap_vld = pipe_vld_q[RAM_LAT-1];
    cap_idx = pipe_idx_q[RAM_LAT-1];
    tap_d   = '0;
    for (int i = 0; i < NTAPS; i++) begin
      tap_d       = delay_q[i*ADDR_W +: ADDR_W];
      shadow_d[i] = shadow_q[i];
      if (cap_vld && (cap_idx == c_idx_w'(i))) begin
        if (!en_q[i]) begin
          shadow_d[i] = '0;
        end else if (tap_d == '0) begin
          shadow_d[i] = sample_q;
        end else if (tap_d > fill_q) begin
          shadow_d[i] = '0;
        end else begin
          shadow_d[i] = ram.ram_rdata;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fc_q         <= '0;
      state_q      <= c_idle;
      cnt_q        <= '0;
      sample_q     <= '0;
      delay_q      <= '0;
      en_q         <= '0;
      wr_ptr_q     <= '0;
      fill_q       <= '0;
      tap_data_q   <= '0;
      taps_valid_q <= 1'b0;
      for (int i = 0; i < NTAPS; i++) begin
        shadow_q[i] <= '0;
      end
      for (int k = 0; k < RAM_LAT; k++) begin
        pipe_vld_q[k] <= 1'b0;
        pipe_idx_q[k] <= '0;
      end
    end else begin
      fc_q         <= fc_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sample_q     <= sample_d;
      delay_q      <= delay_d;
      en_q         <= en_d;
      wr_ptr_q     <= wr_ptr_d;
      fill_q       <= fill_d;
      tap_data_q   <= tap_data_d;
      taps_valid_q <= taps_valid_d;
      for (int i = 0; i < NTAPS; i++) begin
        shadow_q[i] <= shadow_d[i];
      end
      for (int k = 0; k < RAM_LAT; k++) begin
        pipe_vld_q[k] <= pipe_vld_d[k];
        pipe_idx_q[k] <= pipe_idx_d[k];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_delay_line_ctrl.sv
//==============================================================================
// tb_delay_line_ctrl: scoreboard bench for delay_line_ctrl against a sample-history model
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_delay_line_ctrl;

  localparam int ADDR_W       = 4;
  localparam int DATA_W       = 11;
  localparam int NTAPS        = 2;
  localparam int FRAME_CYCLES = 16;
  localparam int RAM_LAT      = 1;
  localparam int WR_CYC       = 1 + NTAPS + RAM_LAT;
  localparam int VAL_CYC      = WR_CYC + 1;
  localparam int MAX_FILL     = (1 << ADDR_W) - 1;

  typedef struct packed {
    logic [NTAPS-1:0][DATA_W-1:0] tap;
    logic [NTAPS-1:0][ADDR_W-1:0] addr;
    logic [ADDR_W-1:0]            wp;
    logic [DATA_W-1:0]            sample;
  } exp_t;

  logic                    clk = 1'b0;
  logic                    reset = 1'b0;
  logic [DATA_W-1:0]       sample_in = '0;
  logic [NTAPS*ADDR_W-1:0] tap_delay = '0;
  logic [NTAPS-1:0]        tap_en = '0;
  logic                    frame_start;
  logic [NTAPS*DATA_W-1:0] tap_data;
  logic                    taps_valid;
  logic [ADDR_W-1:0]       wr_ptr;

  int                      checks = 0;
  int                      errors = 0;
  exp_t                    sbq [$];
  logic [DATA_W-1:0]       hist [$];
  int                      writes = 0;
  logic [NTAPS*DATA_W-1:0] last_taps = '0;
  int                      tb_fc = 0;

  delay_line_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ram_bus ();

  delay_line_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NTAPS(NTAPS),
    .FRAME_CYCLES(FRAME_CYCLES), .RAM_LAT(RAM_LAT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sample_in(sample_in),
    .tap_delay(tap_delay),
    .tap_en(tap_en),
    .ram(ram_bus.master),
    .frame_start(frame_start),
    .tap_data(tap_data),
    .taps_valid(taps_valid),
    .wr_ptr(wr_ptr)
  );

  always #5 clk = ~clk;

  // Behavioural RAM, pre-filled with garbage so the fill guard has something to mask
  logic [DATA_W-1:0] mem [1 << ADDR_W];
  bit                mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < (1 << ADDR_W); i++) mem[i] <= DATA_W'($urandom);
      mem_init <= 1'b1;
    end else if (ram_bus.ram_we) begin
      mem[ram_bus.ram_addr] <= ram_bus.ram_wdata;
    end
    ram_bus.ram_rdata <= mem[ram_bus.ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: frame timing, RAM traffic and scoreboard pops
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      tb_fc = 0;
    end else begin
      chk("frame_start", 32'(frame_start), 32'(tb_fc == 0));
      if (tb_fc >= 1 && tb_fc <= NTAPS) begin
        if (sbq.size() == 0) chk("rd_addr_noexp", 32'(sbq.size()), 32'd1);
        else chk("rd_addr", 32'(ram_bus.ram_addr), 32'(sbq[0].addr[tb_fc-1]));
      end
      chk("ram_we", 32'(ram_bus.ram_we), 32'(tb_fc == WR_CYC));
      if (tb_fc == WR_CYC && sbq.size() > 0) begin
        chk("wr_addr", 32'(ram_bus.ram_addr), 32'(sbq[0].wp));
        chk("wr_data", 32'(ram_bus.ram_wdata), 32'(sbq[0].sample));
      end
      chk("taps_valid", 32'(taps_valid), 32'(tb_fc == VAL_CYC));
      if (taps_valid) begin
        if (sbq.size() == 0) begin
          chk("valid_noexp", 32'(sbq.size()), 32'd1);
        end else begin
          e = sbq.pop_front();
          chk("tap_data", 32'(tap_data), 32'(e.tap));
          chk("wr_ptr", 32'(wr_ptr), 32'(ADDR_W'(e.wp + 1'b1)));
          last_taps = e.tap;
        end
      end else begin
        chk("tap_hold", 32'(tap_data), 32'(last_taps));
      end
      tb_fc = (tb_fc == FRAME_CYCLES - 1) ? 0 : tb_fc + 1;
    end
  end

  task automatic apply_reset(input bit pop_pending);
    reset = 1'b1;
    if (pop_pending && sbq.size() > 0) sbq.delete(sbq.size() - 1);
    hist.delete();
    writes    = 0;
    last_taps = '0;
    #1;
    chk("rst_async_we", 32'(ram_bus.ram_we), 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("rst_we", 32'(ram_bus.ram_we), 32'd0);
    end
    chk("rst_wr_ptr", 32'(wr_ptr), 32'd0);
    chk("rst_tap_data", 32'(tap_data), 32'd0);
    chk("rst_taps_valid", 32'(taps_valid), 32'd0);
    chk("rst_ram_addr", 32'(ram_bus.ram_addr), 32'd0);
    chk("rst_ram_wdata", 32'(ram_bus.ram_wdata), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic wait_frame();
    for (int n = 0; n < 3 * FRAME_CYCLES; n++) begin
      @(negedge clk);
      if (frame_start) return;
    end
    errors++;
    $display("FAIL frame_timeout: no frame_start within %0d cycles", 3 * FRAME_CYCLES);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "frame_start timeout");
  endtask

  // Issue one frame; the model derives expected taps from the write history
  task automatic drive_frame(input logic [DATA_W-1:0] s, input logic [NTAPS*ADDR_W-1:0] d,
                             input logic [NTAPS-1:0] en, input logic [NTAPS*ADDR_W-1:0] mid_d,
                             input bit abort);
    exp_t              e;
    int                fill;
    int                di;
    wait_frame();
    sample_in = s;
    tap_delay = d;
    tap_en    = en;
    fill = (writes > MAX_FILL) ? MAX_FILL : writes;
    for (int i = 0; i < NTAPS; i++) begin
      di = int'(d[i*ADDR_W +: ADDR_W]);
      e.addr[i] = ADDR_W'(writes - di);
      if (!en[i])         e.tap[i] = '0;
      else if (di == 0)   e.tap[i] = s;
      else if (di > fill) e.tap[i] = '0;
      else                e.tap[i] = hist[hist.size() - di];
    end
    e.wp     = ADDR_W'(writes);
    e.sample = s;
    sbq.push_back(e);
    repeat (3) @(negedge clk);
    sample_in = DATA_W'($urandom);
    tap_delay = mid_d;
    tap_en    = NTAPS'($urandom);
    if (abort) begin
      apply_reset(1'b1);
    end else begin
      hist.push_back(s);
      writes++;
    end
  endtask

  task automatic settle_and_reset();
    repeat (4) @(negedge clk);
    apply_reset(1'b0);
  endtask

  function automatic logic [NTAPS*ADDR_W-1:0] dly(input int d1, input int d0);
    return {ADDR_W'(d1), ADDR_W'(d0)};
  endfunction

  initial begin
    #2;
    apply_reset(1'b0);

    for (int k = 0; k < 3; k++)
      drive_frame('0, dly(3, 1), 2'b11, NTAPS*ADDR_W'($urandom), 1'b0);

    settle_and_reset();
    for (int k = 1; k <= 10; k++)
      drive_frame(DATA_W'(k), dly(1, 3), 2'b11, NTAPS*ADDR_W'($urandom), 1'b0);

    settle_and_reset();
    for (int k = 1; k <= 20; k++)
      drive_frame(DATA_W'(k), dly(int'($urandom_range(0, 15)), 15), 2'b11,
                  NTAPS*ADDR_W'($urandom), 1'b0);

    settle_and_reset();
    drive_frame(11'h405, dly(0, 0), 2'b01, NTAPS*ADDR_W'($urandom), 1'b0);

    for (int k = 0; k < 6; k++)
      drive_frame(DATA_W'($urandom), dly(1, 1), 2'b11, NTAPS*ADDR_W'($urandom), 1'b0);
    drive_frame(DATA_W'($urandom), dly(2, 2), 2'b11, dly(5, 5), 1'b0);
    drive_frame(DATA_W'($urandom), dly(5, 5), 2'b11, NTAPS*ADDR_W'($urandom), 1'b0);

    for (int k = 0; k < 30; k++)
      drive_frame(DATA_W'($urandom), NTAPS*ADDR_W'($urandom), NTAPS'($urandom),
                  NTAPS*ADDR_W'($urandom), 1'b0);

    settle_and_reset();
    for (int k = 1; k <= 5; k++)
      drive_frame(DATA_W'(k), dly(1, 2), 2'b11, NTAPS*ADDR_W'($urandom), 1'b0);
    drive_frame(DATA_W'(6), dly(1, 2), 2'b11, NTAPS*ADDR_W'($urandom), 1'b1);
    for (int k = 7; k <= 10; k++)
      drive_frame(DATA_W'(k), dly(1, 2), 2'b11, NTAPS*ADDR_W'($urandom), 1'b0);

    repeat (4) @(negedge clk);
    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
